instr_fetch: RTL

//  Fetch stage of the 16-bit MIPS core: owns the PC, fetches one 16-bit instruction per step from

---
 rtl/instr_fetch_if.sv | 9 +
 rtl/instr_fetch.sv | 92 +++++++++
 2 files changed

// File: rtl/instr_fetch_if.sv
// instr_fetch_if: instruction-memory request/acknowledge bus between fetch stage and imem
interface instr_fetch_if;
   logic        req;
   logic [15:0] addr;
   logic        ack;
   logic [15:0] rdata;
   modport master (output req, addr, input ack, rdata);
   modport slave (input req, addr, output ack, rdata);
endinterface

// File: rtl/instr_fetch.sv
// instr_fetch: PC, imem fetch handshake, instruction register, field split and next-PC select
module instr_fetch #(
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter int unsigned TIMEOUT  = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   instr_fetch_if.master        imem,
   input  logic                 jump_i,
   input  logic                 branch_i,
   input  logic                 alu_zero_i,
   input  logic                 jr_i,
   input  logic [15:0]          jr_target_i,
   input  logic                 stall_i,
   output logic                 instr_valid_o,
   output logic [2:0]           opcode_o,
   output logic [2:0]           rs_o,
   output logic [2:0]           rt_o,
   output logic [2:0]           rd_o,
   output logic [3:0]           funct_o,
   output logic [6:0]           imm7_o,
   output logic [15:0]          pc_o,
   output logic [15:0]          pc_plus2_o,
   output logic                 fetch_err_o
);
   typedef enum logic [1:0] {FETCH, EXEC, ERR} state_t;
   state_t      state_q, state_d;
   logic [15:0] pc_q, pc_d;
   logic [15:0] ir_q, ir_d;
   logic [15:0] tcnt_q, tcnt_d;
   logic [15:0] pc_plus2, br_off, next_pc;
   assign pc_plus2 = pc_q + 16'd2;
   assign br_off   = {{8{ir_q[6]}}, ir_q[6:0], 1'b0};
   assign next_pc  = jr_i                  ? (jr_target_i & 16'hFFFE) :
                     jump_i                ? {pc_plus2[15:14], ir_q[12:0], 1'b0} :
                     (branch_i & alu_zero_i) ? pc_plus2 + br_off : pc_plus2;
   // state register; reset abandons any in-flight fetch and ignores a concurrent ack
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= FETCH;
         pc_q    <= RESET_PC;
         ir_q    <= 16'h0000;
         tcnt_q  <= 16'h0000;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         tcnt_q  <= tcnt_d;
      end
   end
   // next state: latch on ack, count dead fetch cycles, advance PC when the datapath is done
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      tcnt_d  = tcnt_q;
      case (state_q)
         FETCH: begin
            if (imem.ack) begin
               ir_d    = imem.rdata;
               tcnt_d  = 16'h0000;
               state_d = EXEC;
            end else begin
               tcnt_d = tcnt_q + 16'd1;
               if (TIMEOUT != 0 && tcnt_q == 16'(TIMEOUT - 1)) state_d = ERR;
            end
         end
         EXEC: begin
            if (!stall_i) begin
               pc_d    = next_pc;
               state_d = FETCH;
            end
         end
         default: state_d = ERR;
      endcase
   end
   // outputs: request and valid are forced low while reset is held
   always_comb begin
      imem.req      = (state_q == FETCH) & reset;
      imem.addr     = pc_q;
      instr_valid_o = (state_q == EXEC) & reset;
      fetch_err_o   = (state_q == ERR);
      opcode_o      = ir_q[15:13];
      rs_o          = ir_q[12:10];
      rt_o          = ir_q[9:7];
      rd_o          = ir_q[6:4];
      funct_o       = ir_q[3:0];
      imm7_o        = ir_q[6:0];
      pc_o          = pc_q;
      pc_plus2_o    = pc_plus2;
   end
endmodule
